// File: rtl/tmss_lock_ctrl.sv
// TMSS lockout controller: key/bank register decode with DTACK timing, lock/halt
// state machine and boot-ROM mapping for the cartridge slot.
module tmss_lock_ctrl #(
  parameter int                      KEY_WORDS  = 2,
  parameter logic [16*KEY_WORDS-1:0] KEY        = (16*KEY_WORDS)'(128'h5345_4741),
  parameter int                      ROM_AW     = 10,
  parameter int                      DTACK_WAIT = 0
) (
  input  logic              MCLK,
  input  logic              SRES,
  input  logic              tmss_enable,
  input  logic              JAP,
  input  logic              AS,
  input  logic              UDS,
  input  logic              LDS,
  input  logic              RW,
  input  logic [22:0]       VA,
  input  logic [15:0]       VD_i,
  input  logic              CE0_i,
  input  logic              CART,
  input  logic              M3,
  input  logic              INTAK,
  input  logic [15:0]       tmss_data,
  output logic [15:0]       VD_o,
  output logic              data_out_en,
  output logic              DTACK,
  output logic              RESET,
  output logic              CE0_o,
  output logic [ROM_AW-1:0] tmss_address,
  output logic              locked
);

  localparam int          KB       = $clog2(KEY_WORDS);
  localparam int          IW       = (KB > 0) ? KB : 1;
  localparam logic [22:0] KEY_BASE = 23'h50A000 >> KB;

  typedef enum logic [1:0] {B_IDLE = 2'd0, B_WAIT = 2'd1, B_ACK = 2'd2} bus_state_t;
  typedef enum logic [1:0] {L_LOCKED = 2'd0, L_UNLOCKED = 2'd1, L_HALT = 2'd2} lock_state_t;

  // Word 0 is the most significant word of KEY, i.e. the first word the CPU writes.
  function automatic logic [15:0] key_word(input int i);
    key_word = KEY[16*(KEY_WORDS-1-i) +: 16];
  endfunction

  bus_state_t  bus_q, bus_d;
  lock_state_t lock_q, lock_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] key_q [KEY_WORDS];
  logic [15:0] key_d [KEY_WORDS];
  logic        bank_q, bank_d;
  logic        match_q, match_d;
  logic        as_q, as_d;

  logic          key_addr_s;
  logic [IW-1:0] idx_s;
  logic          keyhit_s, bankhit_s, vdphit_s, start_s, romsel_s, ack_entry_s;

  generate
    if (KB == 0) begin : g_single
      assign key_addr_s = (VA == KEY_BASE);
      assign idx_s      = '0;
    end else begin : g_multi
      assign key_addr_s = (VA[22:KB] == KEY_BASE[22-KB:0]);
      assign idx_s      = VA[KB-1:0];
    end
  endgenerate

  assign keyhit_s     = ~AS & ~UDS & ~LDS & key_addr_s;
  assign bankhit_s    = ~AS & ~LDS & (VA == 23'h50A080);
  assign vdphit_s     = ~AS & (VA[22:20] == 3'b110);
  assign start_s      = as_q & ~AS;
  assign romsel_s     = ~bank_q & ~CART & M3;
  assign tmss_address = VA[ROM_AW-1:0];

  always_comb begin
    as_d    = AS;
    bus_d   = bus_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    lock_d  = lock_q;
    key_d   = key_q;
    match_d = 1'b1;

    case (bus_q)
      B_IDLE: begin
        if (start_s && (keyhit_s || bankhit_s)) begin
          if (DTACK_WAIT == 0) begin
            bus_d = B_ACK;
          end else begin
            bus_d = B_WAIT;
            cnt_d = 4'd0;
          end
        end else begin
          bus_d = B_IDLE;
        end
      end
      B_WAIT: begin
        if (AS) begin
          bus_d = B_IDLE;
        end else if (cnt_q == 4'(DTACK_WAIT - 1)) begin
          bus_d = B_ACK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      B_ACK: begin
        if (AS) begin
          bus_d = B_IDLE;
        end else begin
          bus_d = B_ACK;
        end
      end
      default: bus_d = B_IDLE;
    endcase

    // Writes land only on the edge that enters ACK, so each access writes once.
    ack_entry_s = (bus_d == B_ACK) && (bus_q != B_ACK) && !RW;
    if (ack_entry_s && keyhit_s) begin
      key_d[idx_s] = VD_i;
    end else begin
      key_d = key_q;
    end
    if (ack_entry_s && bankhit_s) begin
      bank_d = VD_i[0];
    end else begin
      bank_d = bank_q;
    end

    for (int i = 0; i < KEY_WORDS; i++) begin
      match_d = match_d & (key_q[i] == key_word(i));
    end

    case (lock_q)
      L_LOCKED, L_UNLOCKED: begin
        if (start_s && vdphit_s && !match_q && JAP) begin
          lock_d = L_HALT;
        end else if (match_q) begin
          lock_d = L_UNLOCKED;
        end else begin
          lock_d = L_LOCKED;
        end
      end
      L_HALT:  lock_d = L_HALT;
      default: lock_d = L_HALT;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (SRES) begin
      bus_q   <= B_IDLE;
      lock_q  <= L_LOCKED;
      cnt_q   <= 4'd0;
      bank_q  <= 1'b0;
      match_q <= 1'b0;
      as_q    <= 1'b1;
      for (int i = 0; i < KEY_WORDS; i++) begin
        key_q[i] <= 16'h0000;
      end
    end else begin
      bus_q   <= bus_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      match_q <= match_d;
      as_q    <= as_d;
      for (int i = 0; i < KEY_WORDS; i++) begin
        key_q[i] <= key_d[i];
      end
    end
  end

  // Bypass forces the bus-facing outputs idle while state keeps tracking the bus.
  always_comb begin
    VD_o        = 16'h0000;
    data_out_en = 1'b1;
    DTACK       = 1'b1;
    RESET       = 1'b1;
    CE0_o       = CE0_i;
    locked      = (lock_q != L_UNLOCKED);
    if (tmss_enable) begin
      if (romsel_s) begin
        VD_o = tmss_data;
      end else if (keyhit_s && RW) begin
        VD_o = key_q[idx_s];
      end else if (bankhit_s && RW) begin
        VD_o = {15'b0, bank_q};
      end else begin
        VD_o = 16'h0000;
      end
      data_out_en = ~((romsel_s & ~AS & RW) |
                      ((bus_q == B_ACK) & RW & (keyhit_s | bankhit_s)));
      DTACK       = ~((bus_q == B_ACK) & INTAK);
      RESET       = (lock_q != L_HALT);
      CE0_o       = CE0_i | romsel_s;
    end else begin
      VD_o        = 16'h0000;
      data_out_en = 1'b1;
      DTACK       = 1'b1;
      RESET       = 1'b1;
      CE0_o       = CE0_i;
    end
  end

endmodule

// File: tb/tb_tmss_lock_ctrl.sv
// Scoreboard bench for tmss_lock_ctrl: directed scenarios plus randomized bus
// traffic checked against a register-level reference model.
module tb_tmss_lock_ctrl;

  logic        MCLK = 1'b0, SRES = 1'b1, tmss_enable = 1'b1, JAP = 1'b1;
  logic        AS = 1'b1, UDS = 1'b1, LDS = 1'b1, RW = 1'b1;
  logic        CE0_i = 1'b0, CART = 1'b0, M3 = 1'b1, INTAK = 1'b1;
  logic [22:0] VA = 23'h0;
  logic [15:0] VD_i = 16'h0, tmss_data = 16'hA5C3;

  logic [15:0] vd_o_0, vd_o_1;
  logic        doe_0, doe_1, dtack_0, dtack_1, reset_0, reset_1;
  logic        ce0_o_0, ce0_o_1, locked_0, locked_1;
  logic [9:0]  taddr_0, taddr_1;

  tmss_lock_ctrl dut0 (
    .MCLK(MCLK), .SRES(SRES), .tmss_enable(tmss_enable), .JAP(JAP),
    .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .VA(VA), .VD_i(VD_i),
    .CE0_i(CE0_i), .CART(CART), .M3(M3), .INTAK(INTAK), .tmss_data(tmss_data),
    .VD_o(vd_o_0), .data_out_en(doe_0), .DTACK(dtack_0), .RESET(reset_0),
    .CE0_o(ce0_o_0), .tmss_address(taddr_0), .locked(locked_0));

  tmss_lock_ctrl #(.KEY_WORDS(4), .DTACK_WAIT(3)) dut1 (
    .MCLK(MCLK), .SRES(SRES), .tmss_enable(tmss_enable), .JAP(JAP),
    .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW), .VA(VA), .VD_i(VD_i),
    .CE0_i(CE0_i), .CART(CART), .M3(M3), .INTAK(INTAK), .tmss_data(tmss_data),
    .VD_o(vd_o_1), .data_out_en(doe_1), .DTACK(dtack_1), .RESET(reset_1),
    .CE0_o(ce0_o_1), .tmss_address(taddr_1), .locked(locked_1));

  always #5 MCLK = ~MCLK;

  typedef struct {int lat; bit rd; logic [15:0] vd;} exp_t;
  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;
  int   sel = 0;

  logic [15:0] m_key0 [2];
  logic        m_bank;
  bit          m_halt;

  function automatic logic [15:0] key_word(input int kw, input int i);
    logic [127:0] k;
    k = 128'h5345_4741;
    return 16'(k >> (16 * (kw - 1 - i)));
  endfunction

  function automatic bit m_match0();
    return (m_key0[0] == key_word(2, 0)) && (m_key0[1] == key_word(2, 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge MCLK); #1;
    SRES = 1'b1;
    repeat (2) @(posedge MCLK);
    #1 SRES = 1'b0;
    m_key0[0] = 16'h0; m_key0[1] = 16'h0;
    m_bank = 1'b0; m_halt = 1'b0;
  endtask

  // One 68k access; if an ACK is expected its response is queued for the monitor.
  task automatic bus_access(input logic [22:0] a, input logic rw, input logic [15:0] d,
                            input bit expect_ack, input bit is_rd, input logic [15:0] vexp,
                            input int wait_n, input int idle);
    bit got;
    got = 1'b0;
    if (expect_ack) exp_q.push_back('{lat: wait_n + 1, rd: is_rd, vd: vexp});
    @(posedge MCLK); #1;
    VA = a; RW = rw; VD_i = d; UDS = 1'b0; LDS = 1'b0; AS = 1'b0;
    if (expect_ack) begin
      for (int i = 0; i < 20; i++) begin
        @(negedge MCLK);
        if (((sel != 0) ? dtack_1 : dtack_0) == 1'b0) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        n_tests++;
        n_fail++;
        $display("FAIL ack_timeout addr=%0h: got DTACK=1, expected DTACK=0", a);
        exp_q.delete(exp_q.size() - 1);
      end
    end else begin
      repeat (2) @(negedge MCLK);
    end
    @(posedge MCLK); #1;
    AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
    repeat (idle) @(posedge MCLK);
  endtask

  // Monitor: every falling DTACK of the selected DUT consumes one expected response.
  initial begin
    int          lat;
    logic        pd, dt, oe;
    logic [15:0] vd;
    exp_t        e;
    lat = -1;
    pd  = 1'b1;
    forever begin
      @(negedge MCLK);
      lat = AS ? -1 : lat + 1;
      dt  = (sel != 0) ? dtack_1 : dtack_0;
      vd  = (sel != 0) ? vd_o_1 : vd_o_0;
      oe  = (sel != 0) ? doe_1 : doe_0;
      if (!dt && pd) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_dtack: got DTACK=0 at %0t, expected DTACK=1", $time);
        end else begin
          e = exp_q.pop_front();
          check("dtack_latency", lat, e.lat);
          if (e.rd) check("read_data", vd, e.vd);
          check("data_out_en", oe, e.rd ? 32'd0 : 32'd1);
        end
      end
      pd = dt;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          op, ki;
    logic [15:0] d;
    m_key0[0] = 16'h0; m_key0[1] = 16'h0;
    m_bank = 1'b0; m_halt = 1'b0;

    // Reset state: boot ROM mapped, bus idle, CPU running, locked.
    repeat (2) @(negedge MCLK);
    check("rst_dtack", dtack_0, 1); check("rst_reset", reset_0, 1);
    check("rst_locked", locked_0, 1); check("rst_ce0", ce0_o_0, 1);
    @(posedge MCLK); #1 SRES = 1'b0;
    @(negedge MCLK);
    check("post_rst_dtack", dtack_0, 1); check("post_rst_locked", locked_0, 1);
    check("post_rst_ce0", ce0_o_0, 1);

    // Correct key unlocks two cycles after the second ACK; VDP access is then safe.
    CART = 1'b1; JAP = 1'b1;
    bus_access(23'h50A000, 1'b0, 16'h5345, 1, 0, 16'h0, 0, 3);
    bus_access(23'h50A001, 1'b0, 16'h4741, 1, 0, 16'h0, 0, 0);
    m_key0[0] = 16'h5345; m_key0[1] = 16'h4741;
    check("locked_ack_plus1", locked_0, 1);
    @(negedge MCLK); check("locked_ack_plus1b", locked_0, 1);
    @(negedge MCLK); check("locked_ack_plus2", locked_0, 0);
    bus_access(23'h50A000, 1'b1, 16'h0, 1, 1, 16'h5345, 0, 1);
    bus_access(23'h600000, 1'b1, 16'h0, 0, 0, 16'h0, 0, 3);
    @(negedge MCLK); check("vdp_unlocked_reset", reset_0, 1); check("unlocked", locked_0, 0);

    // Wrong key then VDP access halts the CPU; halt survives the right key.
    do_reset();
    bus_access(23'h50A000, 1'b0, 16'h5345, 1, 0, 16'h0, 0, 3);
    bus_access(23'h50A001, 1'b0, 16'h4740, 1, 0, 16'h0, 0, 3);
    @(posedge MCLK); #1;
    VA = 23'h600002; RW = 1'b1; AS = 1'b0;
    @(negedge MCLK); check("halt_before_edge", reset_0, 1);
    @(negedge MCLK); check("halt_reset", reset_0, 0);
    @(posedge MCLK); #1 AS = 1'b1;
    bus_access(23'h50A001, 1'b0, 16'h4741, 1, 0, 16'h0, 0, 3);
    @(negedge MCLK); check("halt_sticky", reset_0, 0); check("halt_locked", locked_0, 1);
    tmss_enable = 1'b0; CE0_i = 1'b1; #1;
    check("byp_reset", reset_0, 1); check("byp_dtack", dtack_0, 1);
    check("byp_doe", doe_0, 1); check("byp_vd", vd_o_0, 0); check("byp_ce0", ce0_o_0, 1);
    tmss_enable = 1'b1; CE0_i = 1'b0;
    do_reset();
    @(negedge MCLK); check("sres_clears_halt", reset_0, 1); check("sres_locked", locked_0, 1);

    // Outside Japan the lockout never halts.
    JAP = 1'b0;
    bus_access(23'h600000, 1'b1, 16'h0, 0, 0, 16'h0, 0, 3);
    @(negedge MCLK); check("nojap_reset", reset_0, 1); check("nojap_locked", locked_0, 1);
    JAP = 1'b1;

    // Boot ROM mapping and bank switch.
    do_reset();
    CART = 1'b0; M3 = 1'b1; CE0_i = 1'b0; tmss_data = 16'($urandom);
    @(posedge MCLK); #1;
    VA = 23'h000080; RW = 1'b1; AS = 1'b0; UDS = 1'b0; LDS = 1'b0;
    @(negedge MCLK);
    check("rom_data", vd_o_0, tmss_data); check("rom_ce0", ce0_o_0, 1);
    check("rom_doe", doe_0, 0); check("rom_addr", taddr_0, 10'h080);
    tmss_enable = 1'b0; #1;
    check("rom_byp_vd", vd_o_0, 0); check("rom_byp_ce0", ce0_o_0, 0);
    tmss_enable = 1'b1;
    @(posedge MCLK); #1 AS = 1'b1; UDS = 1'b1; LDS = 1'b1;
    bus_access(23'h50A080, 1'b0, 16'h0001, 1, 0, 16'h0, 0, 3);
    m_bank = 1'b1;
    @(negedge MCLK); check("bank_ce0_lo", ce0_o_0, 0);
    CE0_i = 1'b1; #1 check("bank_ce0_hi", ce0_o_0, 1);
    CE0_i = 1'b0;
    bus_access(23'h50A080, 1'b1, 16'h0, 1, 1, 16'h0001, 0, 3);

    // Randomized traffic against the register-level model.
    CART = 1'b1;
    do_reset();
    for (int n = 0; n < 90; n++) begin
      JAP = ($urandom_range(0, 3) != 0);
      op  = $urandom_range(0, 5);
      ki  = $urandom_range(0, 1);
      d   = 16'($urandom);
      case (op)
        0: begin
          if ($urandom_range(0, 9) < 7) d = key_word(2, ki);
          bus_access(23'h50A000 | 23'(ki), 1'b0, d, 1, 0, 16'h0, 0, 3);
          m_key0[ki] = d;
        end
        1: bus_access(23'h50A000 | 23'(ki), 1'b1, 16'h0, 1, 1, m_key0[ki], 0, 3);
        2: begin
          bus_access(23'h50A080, 1'b0, d, 1, 0, 16'h0, 0, 3);
          m_bank = d[0];
        end
        3: bus_access(23'h50A080, 1'b1, 16'h0, 1, 1, {15'b0, m_bank}, 0, 3);
        4: begin
          bus_access(23'h600000 | 23'(d), 1'b1, 16'h0, 0, 0, 16'h0, 0, 3);
          if (JAP && !m_match0()) m_halt = 1'b1;
        end
        default: begin
          if ($urandom_range(0, 3) == 0) do_reset();
          else bus_access(23'h100000 | 23'(d), 1'b1, 16'h0, 0, 0, 16'h0, 0, 3);
        end
      endcase
      @(negedge MCLK);
      check("rand_locked", locked_0, (m_halt || !m_match0()) ? 32'd1 : 32'd0);
      check("rand_reset", reset_0, m_halt ? 32'd0 : 32'd1);
    end

    // Wait states and four-word key on the second instance.
    sel = 1;
    do_reset();
    bus_access(23'h50A002, 1'b0, 16'h1234, 1, 0, 16'h0, 3, 3);
    @(posedge MCLK); #1;
    VA = 23'h50A003; RW = 1'b0; VD_i = 16'hBEEF; UDS = 1'b0; LDS = 1'b0; AS = 1'b0;
    repeat (2) @(posedge MCLK);
    #1 AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
    repeat (6) @(posedge MCLK);
    bus_access(23'h50A003, 1'b1, 16'h0, 1, 1, 16'h0000, 3, 3);
    bus_access(23'h50A002, 1'b1, 16'h0, 1, 1, 16'h1234, 3, 3);
    @(negedge MCLK); check("w4_locked", locked_1, 1);

    // Reset during the wait phase aborts the write.
    @(posedge MCLK); #1;
    VA = 23'h50A002; RW = 1'b0; VD_i = 16'h5555; UDS = 1'b0; LDS = 1'b0; AS = 1'b0;
    @(posedge MCLK); #1 SRES = 1'b1;
    @(negedge MCLK); check("abort_dtack", dtack_1, 1); check("abort_locked", locked_1, 1);
    @(posedge MCLK); #1;
    SRES = 1'b0; AS = 1'b1; UDS = 1'b1; LDS = 1'b1; RW = 1'b1;
    repeat (2) @(posedge MCLK);
    bus_access(23'h50A002, 1'b1, 16'h0, 1, 1, 16'h0000, 3, 3);

    repeat (4) @(posedge MCLK);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_responses: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
